// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - paddle position generator and line-count comparator for the game core
// Digital, analog-stick and paddle sources; sampled once per measurement window.
module paddle_ctrl #(
  parameter logic [7:0] POS_INIT     = 8'd114,
  parameter int         DELTA_SLOW   = 4,
  parameter int         DELTA_FAST   = 8,
  parameter int         ACCEL_FRAMES = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        pad_en_n,
  input  logic        player2,
  input  logic        speed,
  input  logic [2:0]  p1_mode,
  input  logic [2:0]  p2_mode,
  input  logic        p1_left,
  input  logic        p1_right,
  input  logic        p2_left,
  input  logic        p2_right,
  input  logic [15:0] p1_analog,
  input  logic [15:0] p2_analog,
  input  logic [7:0]  paddle_0,
  input  logic [7:0]  paddle_1,
  output logic        pad_out,
  output logic [7:0]  pos_active
);

  localparam logic [8:0] STEP_SLOW = 9'(DELTA_SLOW);
  localparam logic [8:0] STEP_FAST = 9'(DELTA_FAST);
  localparam logic [4:0] ACCEL     = 5'(ACCEL_FRAMES);

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  logic       hs_r, hs_p, vs_r, vs_p, pe_r, pe_p;
  logic       p2_q, armed;
  logic [7:0] pos1, pos2, line_cnt;
  logic [3:0] hold;
  dir_t       last_dir;

  logic       hs_edge, vs_edge, pe_fall;
  logic       dir_l, dir_r;
  dir_t       cur_dir;
  logic [3:0] eff_hold;
  logic [8:0] base, step, cur_pos, next_pos;
  logic [7:0] sel1, sel2, selected;

  assign hs_edge = hs_r & ~hs_p;
  assign vs_edge = vs_r & ~vs_p;
  assign pe_fall = pe_p & ~pe_r;

  function automatic logic [7:0] sel_pos(input logic [2:0] mode, input logic [15:0] analog,
                                         input logic [7:0] paddle, input logic [7:0] dig);
    logic [7:0] x, y;
    x = {~analog[7], analog[6:0]};
    y = {~analog[15], analog[14:8]};
    case (mode)
      3'd0:    sel_pos = dig;
      3'd1:    sel_pos = ~x;
      3'd2:    sel_pos = x;
      3'd3:    sel_pos = ~y;
      3'd4:    sel_pos = y;
      3'd5:    sel_pos = ~paddle;
      3'd6:    sel_pos = paddle;
      default: sel_pos = POS_INIT;
    endcase
  endfunction

  assign sel1     = sel_pos(p1_mode, p1_analog, paddle_0, pos1);
  assign sel2     = sel_pos(p2_mode, p2_analog, paddle_1, pos2);
  assign selected = player2 ? sel2 : sel1;

  // Hold count only carries over while the same player keeps the same single direction.
  always_comb begin
    dir_l   = player2 ? p2_left  : p1_left;
    dir_r   = player2 ? p2_right : p1_right;
    cur_dir = DIR_NONE;
    if (dir_r && !dir_l)      cur_dir = DIR_RIGHT;
    else if (dir_l && !dir_r) cur_dir = DIR_LEFT;
    eff_hold = (cur_dir == last_dir && player2 == p2_q) ? hold : 4'd0;
    base     = speed ? STEP_FAST : STEP_SLOW;
    step     = ({1'b0, eff_hold} < ACCEL) ? base : {base[7:0], 1'b0};
    cur_pos  = {1'b0, (player2 ? pos2 : pos1)};
    next_pos = cur_pos;
    if (cur_dir == DIR_RIGHT)
      next_pos = (cur_pos < step) ? 9'd0 : cur_pos - step;
    else if (cur_dir == DIR_LEFT)
      next_pos = ((cur_pos + step) > 9'd255) ? 9'd255 : cur_pos + step;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_r       <= 1'b0;
      hs_p       <= 1'b0;
      vs_r       <= 1'b0;
      vs_p       <= 1'b0;
      pe_r       <= 1'b0;
      pe_p       <= 1'b0;
      p2_q       <= 1'b0;
      armed      <= 1'b0;
      pos1       <= POS_INIT;
      pos2       <= POS_INIT;
      pos_active <= POS_INIT;
      line_cnt   <= 8'd0;
      hold       <= 4'd0;
      last_dir   <= DIR_NONE;
      pad_out    <= 1'b0;
    end else begin
      hs_r <= hsync;
      hs_p <= hs_r;
      vs_r <= vsync;
      vs_p <= vs_r;
      pe_r <= pad_en_n;
      pe_p <= pe_r;
      p2_q <= player2;

      if (vs_edge && cur_dir != DIR_NONE) begin
        if (player2) pos2 <= next_pos[7:0];
        else         pos1 <= next_pos[7:0];
        hold     <= (eff_hold == 4'd15) ? 4'd15 : eff_hold + 4'd1;
        last_dir <= cur_dir;
      end else if (cur_dir != last_dir || player2 != p2_q) begin
        hold     <= 4'd0;
        last_dir <= DIR_NONE;
      end

      if (pe_fall) begin
        pos_active <= selected;
        armed      <= 1'b1;
      end

      // A window interrupted by reset stays idle until the next arm.
      if (!pe_r)
        line_cnt <= 8'd0;
      else if (armed && hs_edge && line_cnt != 8'd255)
        line_cnt <= line_cnt + 8'd1;

      pad_out <= (line_cnt < pos_active);
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - scoreboard bench for paddle_ctrl with a frame-level position model
module tb_paddle_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        hsync = 1'b0, vsync = 1'b0, pad_en_n = 1'b1;
  logic        player2 = 1'b0, speed = 1'b0;
  logic [2:0]  p1_mode = 3'd0, p2_mode = 3'd0;
  logic        p1_left = 1'b0, p1_right = 1'b0, p2_left = 1'b0, p2_right = 1'b0;
  logic [15:0] p1_analog = 16'd0, p2_analog = 16'd0;
  logic [7:0]  paddle_0 = 8'd0, paddle_1 = 8'd0;
  logic        pad_out;
  logic [7:0]  pos_active;

  paddle_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .pad_en_n(pad_en_n), .player2(player2), .speed(speed),
    .p1_mode(p1_mode), .p2_mode(p2_mode),
    .p1_left(p1_left), .p1_right(p1_right), .p2_left(p2_left), .p2_right(p2_right),
    .p1_analog(p1_analog), .p2_analog(p2_analog),
    .paddle_0(paddle_0), .paddle_1(paddle_1),
    .pad_out(pad_out), .pos_active(pos_active)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string name;
    int    kind;
    int    exp;
  } item_t;

  item_t sb[$];
  event  chk_ev;
  int    total = 0;
  int    bad = 0;

  int m_pos[2];
  int m_run;
  int m_dir;

  initial begin : monitor
    item_t it;
    int    act;
    forever begin
      @(chk_ev);
      @(negedge clk_sys);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          0:       act = int'(pad_out);
          1:       act = int'(pos_active);
          default: act = int'(dut.hold);
        endcase
        total++;
        if (act != it.exp) begin
          bad++;
          $display("FAIL %s: got %0d want %0d", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_out(input string nm, input int kind, input int ex);
    item_t it;
    it.name = nm;
    it.kind = kind;
    it.exp  = ex;
    sb.push_back(it);
  endtask

  task automatic check_now;
    ->chk_ev;
    tick(1);
  endtask

  function automatic int sel_model(input int mode, input int analog, input int paddle, input int dig);
    int x, y;
    x = (analog % 256 + 128) % 256;
    y = ((analog / 256) % 256 + 128) % 256;
    case (mode)
      0:       return dig;
      1:       return 255 - x;
      2:       return x;
      3:       return 255 - y;
      4:       return y;
      5:       return 255 - paddle;
      6:       return paddle;
      default: return 114;
    endcase
  endfunction

  task automatic model_reset;
    m_pos[0] = 114;
    m_pos[1] = 114;
    m_run    = 0;
    m_dir    = 0;
  endtask

  task automatic set_p2(input logic v);
    if (v !== player2) begin
      m_run = 0;
      m_dir = 0;
    end
    player2 = v;
  endtask

  // One vsync frame: the model moves the active player's position by the current step.
  task automatic do_frame;
    int l, r, base, step, d, np;
    l    = player2 ? int'(p2_left)  : int'(p1_left);
    r    = player2 ? int'(p2_right) : int'(p1_right);
    base = speed ? 8 : 4;
    if (l == r) begin
      m_run = 0;
      m_dir = 0;
    end else begin
      d = r ? -1 : 1;
      if (d != m_dir) m_run = 0;
      step = (m_run < 8) ? base : 2 * base;
      np   = m_pos[int'(player2)] + d * step;
      if (np < 0)   np = 0;
      if (np > 255) np = 255;
      m_pos[int'(player2)] = np;
      m_run = (m_run < 15) ? m_run + 1 : 15;
      m_dir = d;
    end
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic do_window(output int ex);
    pad_en_n = 1'b0;
    tick(3);
    pad_en_n = 1'b1;
    tick(2);
    if (player2) ex = sel_model(int'(p2_mode), int'(p2_analog), int'(paddle_1), m_pos[1]);
    else         ex = sel_model(int'(p1_mode), int'(p1_analog), int'(paddle_0), m_pos[0]);
  endtask

  task automatic hpulses(input int n);
    repeat (n) begin
      hsync = 1'b1;
      tick(2);
      hsync = 1'b0;
      tick(2);
    end
  endtask

  initial begin
    int ex, n, cnt;
    model_reset();
    tick(3);
    expect_out("reset_pad_out", 0, 0);
    expect_out("reset_pos_active", 1, 114);
    check_now();
    reset_n = 1'b1;
    tick(2);

    do_window(ex);
    expect_out("win0_pos_active", 1, ex);
    expect_out("win0_pad_out", 0, 1);
    check_now();
    hpulses(113);
    expect_out("edges113_pad_out", 0, 1);
    check_now();
    hpulses(1);
    expect_out("edges114_pad_out", 0, 0);
    check_now();
    hpulses(150);
    expect_out("count_saturate_pad_out", 0, 0);
    check_now();

    p1_left  = 1'b1;
    p1_right = 1'b1;
    repeat (5) do_frame();
    expect_out("both_held_hold", 2, 0);
    do_window(ex);
    expect_out("both_held_pos1", 1, ex);
    expect_out("both_held_pos1_const", 1, 114);
    check_now();
    p1_left  = 1'b0;
    p1_right = 1'b0;

    p1_mode   = 3'd1;
    p1_analog = 16'h0000;
    do_window(ex);
    expect_out("mode1_x00", 1, 8'h7F);
    check_now();
    p1_mode = 3'd2;
    do_window(ex);
    expect_out("mode2_x00", 1, 8'h80);
    check_now();

    set_p2(1'b1);
    p2_mode  = 3'd5;
    paddle_1 = 8'h10;
    p1_right = 1'b1;
    do_frame();
    do_window(ex);
    expect_out("p2_paddle_inv", 1, 8'hEF);
    check_now();
    p1_right = 1'b0;
    set_p2(1'b0);
    p1_mode = 3'd0;
    do_window(ex);
    expect_out("pos1_untouched", 1, 114);
    check_now();

    set_p2(1'b1);
    tick(4);
    expect_out("p2_toggle_midwindow", 1, ex);
    check_now();
    set_p2(1'b0);

    speed    = 1'b0;
    p1_right = 1'b1;
    for (int f = 1; f <= 40; f++) begin
      do_frame();
      do_window(ex);
      expect_out($sformatf("right_hold_f%0d", f), 1, ex);
      if (f == 1) expect_out("right_first_step", 1, 110);
      if (f == 9) expect_out("right_accel_step", 1, 74);
      check_now();
    end
    expect_out("right_saturated", 1, 0);
    check_now();
    p1_right = 1'b0;

    for (int i = 0; i < 40; i++) begin
      set_p2(1'($urandom_range(0, 1)));
      speed = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        p1_left  = 1'($urandom_range(0, 1));
        p1_right = 1'($urandom_range(0, 1));
        p2_left  = 1'($urandom_range(0, 1));
        p2_right = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(1, 4)) do_frame();
      p1_mode   = 3'($urandom_range(0, 7));
      p2_mode   = 3'($urandom_range(0, 7));
      p1_analog = 16'($urandom);
      p2_analog = 16'($urandom);
      paddle_0  = 8'($urandom);
      paddle_1  = 8'($urandom);
      do_window(ex);
      expect_out($sformatf("rand%0d_pos_active", i), 1, ex);
      check_now();
      n = (i == 7) ? 270 : $urandom_range(0, 60);
      hpulses(n);
      cnt = (n > 255) ? 255 : n;
      expect_out($sformatf("rand%0d_pad_out_n%0d", i, n), 0, (cnt < ex) ? 1 : 0);
      check_now();
    end

    p1_left = 1'b0; p1_right = 1'b0; p2_left = 1'b0; p2_right = 1'b0;
    set_p2(1'b0);
    p1_mode = 3'd0;
    do_window(ex);
    hpulses(50);
    expect_out("cnt50_pad_out", 0, (50 < ex) ? 1 : 0);
    check_now();
    reset_n = 1'b0;
    model_reset();
    expect_out("midreset_pad_out", 0, 0);
    expect_out("midreset_pos_active", 1, 114);
    check_now();
    tick(2);
    reset_n = 1'b1;
    tick(3);
    expect_out("postreset_pad_out", 0, 1);
    check_now();
    hpulses(120);
    expect_out("postreset_no_count", 0, 1);
    check_now();
    do_window(ex);
    expect_out("postreset_pos1", 1, 114);
    check_now();
    hpulses(120);
    expect_out("postreset_counting", 0, 0);
    check_now();

    tick(4);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
